// File: rtl/nn_pkg.sv
// Shared types, FSM encoding and a generic signed clamp for the neuron MAC datapath.
package nn_pkg;

  localparam int NN_DATA_BITS = 16;
  localparam int NN_FRAC_BITS = 8;
  localparam int NN_ACC_BITS  = 32;

  typedef logic signed [NN_DATA_BITS-1:0] data_t;
  typedef logic signed [NN_ACC_BITS-1:0]  acc_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FLUSH = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } mac_state_e;

  // Clamp v into the signed range of a 'bits'-wide integer; caller keeps the low bits.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_saturate.sv
// Combinational signed W-bit add that clamps to the W-bit range and flags when it did.
module mac_saturate #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  logic signed [W:0] full;

  assign full = $signed({a[W-1], a}) + $signed({b[W-1], b});
  // One guard bit suffices: the two top bits disagree exactly when the W-bit result wrapped.
  assign ovf  = full[W] ^ full[W-1];
  assign sum  = !ovf     ? full[W-1:0] :
                full[W]  ? {1'b1, {(W-1){1'b0}}} :
                           {1'b0, {(W-1){1'b1}}};

endmodule

// File: rtl/neuron_mac.sv
// Streamed x*w multiply-accumulate plus bias with saturated Q-format result; two cycles from last pair to out_valid.
// Defining NEURON_MAC_RELU_EN applies ReLU to the rounded result; out_valid is held until out_ready.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int DATA_BITS = NN_DATA_BITS,
  parameter int FRAC_BITS = NN_FRAC_BITS,
  parameter int ACC_BITS  = NN_ACC_BITS,
  parameter int MAX_TERMS = 784,
  parameter int CNT_BITS  = $clog2(MAX_TERMS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_BITS-1:0]         num_terms,
  input  logic signed [DATA_BITS-1:0] bias,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_BITS-1:0] x,
  input  logic signed [DATA_BITS-1:0] w,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_BITS-1:0] out_sum,
  output logic                        busy,
  output logic                        overflow
);

  localparam int PW = 2 * DATA_BITS;

  mac_state_e state, state_next;

  logic [CNT_BITS-1:0]         cnt, n_lat, cnt_inc;
  logic signed [ACC_BITS-1:0]  acc, acc_next, prod_ext, bias_acc;
  logic signed [PW-1:0]        prod;
  logic                        prod_vld, acc_ovf, beat, start_acc;
  logic signed [63:0]          shifted, narrowed;
  logic signed [DATA_BITS-1:0] round_val;
  logic                        round_ovf;

  assign beat      = in_valid && in_ready;
  assign start_acc = (state == IDLE) && start;
  assign cnt_inc   = cnt + 1'b1;
  assign prod_ext  = ACC_BITS'(prod);
  assign bias_acc  = ACC_BITS'(bias) <<< FRAC_BITS;

  mac_saturate #(.W(ACC_BITS)) u_sat (
    .a   (acc),
    .b   (prod_ext),
    .sum (acc_next),
    .ovf (acc_ovf)
  );

  always_comb begin
    shifted   = 64'(acc >>> FRAC_BITS);
    narrowed  = sat_narrow(shifted, DATA_BITS);
    round_ovf = (narrowed != shifted);
    round_val = narrowed[DATA_BITS-1:0];
`ifdef NEURON_MAC_RELU_EN
    if (round_val[DATA_BITS-1]) round_val = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_terms != '0) ? ACCUM : ROUND;
      ACCUM:   if (beat && (cnt_inc == n_lat)) state_next = FLUSH;
      FLUSH:   state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // The product lands one cycle after its beat and is folded into acc on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      n_lat    <= '0;
      acc      <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      out_sum  <= '0;
      overflow <= 1'b0;
    end else if (start_acc) begin
      n_lat    <= (num_terms > CNT_BITS'(MAX_TERMS)) ? CNT_BITS'(MAX_TERMS) : num_terms;
      cnt      <= '0;
      acc      <= bias_acc;
      prod_vld <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prod_vld <= beat;
      if (beat) begin
        prod <= PW'(x) * PW'(w);
        cnt  <= cnt_inc;
      end
      if (prod_vld) begin
        acc <= acc_next;
        if (acc_ovf) overflow <= 1'b1;
      end
      if (state == ROUND) begin
        out_sum <= round_val;
        if (round_ovf) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Sequential multiply-accumulate stage computing one MLP neuron pre-activation: sum(x_i*w_i) + bias over a streamed vector.
- Sits directly upstream of the layer's activation/adder chain; one instance per neuron lane.
- Consumes (x, w) pairs over a valid/ready stream and produces one saturated fixed-point result per computation over a valid/ready output.

Parameters:
- DATA_BITS, 16, width of x, w, bias, out_sum (signed Q(DATA_BITS-FRAC_BITS).FRAC_BITS).
- FRAC_BITS, 8, fractional bits of data operands.
- ACC_BITS, 32, signed accumulator width (Q.2*FRAC_BITS).
- MAX_TERMS, 784, maximum terms per computation.
- CNT_BITS, $clog2(MAX_TERMS+1), width of term counter and num_terms.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin computation; sampled only in IDLE
- num_terms  input  CNT_BITS  term count, latched with start; 0..MAX_TERMS
- bias  input  DATA_BITS  signed bias, latched with start
- in_valid  input  1  x/w pair valid
- in_ready  output  1  pair accepted when in_valid&&in_ready
- x  input  DATA_BITS  signed activation
- w  input  DATA_BITS  signed weight
- out_valid  output  1  out_sum valid
- out_ready  input  1  consumer accepts result
- out_sum  output  DATA_BITS  signed saturated result
- busy  output  1  high in any state but IDLE
- overflow  output  1  sticky saturation flag for current/last computation

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, out_valid, busy, overflow = 0; out_sum, accumulator, product register, counter = 0.
- FSM states: IDLE, ACCUM, FLUSH, ROUND, DONE.
- IDLE: when start=1, latch num_terms, clear overflow, load acc = sign-extended bias <<< FRAC_BITS. Go to ACCUM if num_terms>0, else ROUND. start in any other state is ignored.
- ACCUM: in_ready=1. Each accepted beat registers prod = x*w as a full 2*DATA_BITS signed product and increments the counter.
  - In the cycle after a beat, acc = sat(acc + sign-extended prod).
  - On the beat where count reaches num_terms, go to FLUSH.
  - Gaps in in_valid stall without side effects.
- FLUSH: in_ready=0; the final product is added; go to ROUND.
- ROUND: out_sum <= clamp(acc >>> FRAC_BITS) to DATA_BITS range (arithmetic shift, floor). Set out_valid. Go to DONE.
- DONE: out_valid=1; out_sum and overflow held stable until out_ready=1. On out_valid&&out_ready, clear out_valid and go to IDLE. A new start is accepted no earlier than the following cycle.
- Latency: last pair accepted at edge k gives out_valid high after edge k+2. With num_terms=0, start at edge s gives out_valid after edge s+1.
- Saturation:
  - The accumulator add clamps to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1].
  - The output narrowing clamps to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
  - Either event sets overflow, which holds until the next accepted start.
- num_terms > MAX_TERMS: clamped to MAX_TERMS at latch.
- Reset mid-operation: immediate return to IDLE with reset values; the partial result is discarded.

Optional Feature:
- NEURON_MAC_RELU_EN defined: ROUND applies ReLU after clamping, so a negative result gives out_sum=0. overflow is unaffected.
- Not defined: the signed result passes through unchanged.

Decomposition:
- Shared package nn_pkg:
  - typedef data_t (signed DATA_BITS) and acc_t (signed ACC_BITS).
  - FRAC_BITS default constant.
  - FSM state enum mac_state_e.
  - Function sat_narrow (generic clamp).
- One sub-module: mac_saturate, combinational signed add with clamp and overflow flag. It is used for the accumulator step; ROUND reuses the sat_narrow function.

Test Plan:
- Basic sum:
  - Stimulus: num_terms=3, bias=0x0080; pairs (0x0100,0x0200), (0x0180,0x0100), (0xFF00,0x0100), back-to-back.
  - Required: out_sum=0x0300; overflow=0; out_valid exactly 2 edges after the 3rd accept.
- Zero terms:
  - Stimulus: num_terms=0, bias=0xFF80.
  - Required: out_sum=0xFF80 one edge after start; in_ready never high.
- Saturation:
  - Stimulus: num_terms=2, bias=0x7FFF; pairs (0x7FFF,0x7FFF) x2.
  - Required: accumulator clamps to 0x7FFFFFFF; out_sum=0x7FFF; overflow=1; overflow clears on the next start.
- Backpressure:
  - Stimulus: in_valid toggled 1-0-1-0; out_ready held low 5 cycles with start pulsed during DONE.
  - Required: result identical to the basic sum; out_sum stable; start ignored; IDLE entered only on out_ready.
- Reset mid-ACCUM:
  - Stimulus: rst_n low after 1 of 3 beats.
  - Required: all outputs 0 asynchronously; a subsequent basic-sum run returns 0x0300.
- NEURON_MAC_RELU_EN:
  - Stimulus: num_terms=1, bias=0, pair (0xFF00,0x0200) (expected -2.0).
  - Required: out_sum=0x0000 with the macro defined; 0xFE00 without.
